monolith_perm_ctrl: RTL

- Sequencer that runs a full Monolith permutation by iterating a single external round datapath (bars -> bricks -> concrete) NUM_ROUNDS times.
- Accepts a state over a valid/ready input handshake and launches one round at a time with a round index, so the datapath can select round constants.
- Captures each round result and feeds it back, then returns the final state over a valid/ready output handshake.
- Sits between the sponge/hash front-end and the round datapath.
- Includes a watchdog that flags a datapath that never completes a round.

---
 rtl/monolith_perm_ctrl.sv | 122 ++++++++++++
 1 files changed

// File: rtl/monolith_perm_ctrl.sv
// ---------------------------------------------------------------------------
// monolith_perm_ctrl
//   Runs a full Monolith permutation by iterating one external round datapath
//   (bars -> bricks -> concrete) NUM_ROUNDS times. A state arrives over a
//   valid/ready handshake, each round is launched with a one-cycle pulse and
//   a round index, the round result is captured and fed back, and the final
//   state leaves over a second valid/ready handshake. A watchdog aborts the
//   permutation and raises a sticky error if the datapath stalls.
//
// State vectors are flattened: word i lives at bits [i*WORD_WIDTH +: WORD_WIDTH].
//
// Ports
//   clk, reset          clock, asynchronous active-low reset
//   in_valid/in_ready   input state handshake, in_state = permutation input
//   out_valid/out_ready result handshake, out_state = permutation output
//   rnd_start           one-cycle launch pulse to the round datapath
//   rnd_idx, rnd_last   current round index, high on the final round
//   rnd_state_out       state presented to the datapath
//   rnd_state_in        datapath result, qualified by rnd_valid
//   busy                high whenever the sequencer is not idle
//   err                 sticky watchdog error, cleared by the next accepted input
// ---------------------------------------------------------------------------
module monolith_perm_ctrl #(
    parameter int WORD_WIDTH = 31,
    parameter int STATE_SIZE = 16,
    parameter int NUM_ROUNDS = 6,
    parameter int TIMEOUT    = 64,
    localparam int STATE_BITS = WORD_WIDTH * STATE_SIZE,
    localparam int IDX_W      = (NUM_ROUNDS > 1) ? $clog2(NUM_ROUNDS) : 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [STATE_BITS-1:0] in_state,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [STATE_BITS-1:0] out_state,
    output logic                  rnd_start,
    output logic [IDX_W-1:0]      rnd_idx,
    output logic                  rnd_last,
    output logic [STATE_BITS-1:0] rnd_state_out,
    input  logic [STATE_BITS-1:0] rnd_state_in,
    input  logic                  rnd_valid,
    output logic                  busy,
    output logic                  err
);

    // TIMEOUT >= 2 keeps this at least one bit wide; TIMEOUT-1 always fits.
    localparam int WD_W = $clog2(TIMEOUT);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] WAIT  = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    localparam logic [IDX_W-1:0] LAST_RND = IDX_W'(NUM_ROUNDS - 1);
    localparam logic [WD_W-1:0]  WD_LIMIT = WD_W'(TIMEOUT - 1);

    logic [1:0]            fsm;
    logic [STATE_BITS-1:0] state;
    logic [IDX_W-1:0]      rnd_cnt;
    logic [WD_W-1:0]       wd_cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fsm     <= IDLE;
            state   <= '0;
            rnd_cnt <= '0;
            wd_cnt  <= '0;
            err     <= 1'b0;
        end else begin
            case (fsm)
                IDLE: begin
                    if (in_valid) begin
                        state   <= in_state;
                        rnd_cnt <= '0;
                        err     <= 1'b0;
                        fsm     <= ISSUE;
                    end
                end
                ISSUE: begin
                    // Any rnd_valid seen here belongs to no launched round.
                    wd_cnt <= '0;
                    fsm    <= WAIT;
                end
                WAIT: begin
                    if (rnd_valid) begin
                        state <= rnd_state_in;
                        if (rnd_cnt == LAST_RND) begin
                            fsm <= DONE;
                        end else begin
                            rnd_cnt <= rnd_cnt + 1'b1;
                            fsm     <= ISSUE;
                        end
                    end else if (wd_cnt == WD_LIMIT) begin
                        // Stalled datapath: drop the partial state, never
                        // present a result.
                        err <= 1'b1;
                        fsm <= IDLE;
                    end else begin
                        wd_cnt <= wd_cnt + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) fsm <= IDLE;
                end
                default: fsm <= IDLE;
            endcase
        end
    end

    assign in_ready      = (fsm == IDLE);
    assign out_valid     = (fsm == DONE);
    assign rnd_start     = (fsm == ISSUE);
    assign busy          = (fsm != IDLE);
    assign rnd_idx       = rnd_cnt;
    assign rnd_last      = (rnd_cnt == LAST_RND);
    assign rnd_state_out = state;
    assign out_state     = state;

endmodule
